// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an optional
// two-entry skid buffer. Control bits read as zero whenever the stage holds a bubble.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        COUNT
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    assign OUT_VALID = main_valid;
    assign OUT_DATA  = main_data;
    assign OUT_CTRL  = main_ctrl;

    generate
        if (SKID == 0) begin : g_reg
            assign IN_READY = ~main_valid | OUT_READY;
            assign COUNT    = {1'b0, main_valid};

            always_ff @(posedge CLK) begin
                if (RST) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else if (FLUSH) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (IN_READY) begin
                    main_valid <= IN_VALID;
                    main_data  <= IN_DATA;
                    main_ctrl  <= IN_VALID ? IN_CTRL : '0;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t            state;
            logic              in_ready_r;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic              in_fire;
            logic              out_fire;

            assign in_fire  = IN_VALID & in_ready_r;
            assign out_fire = main_valid & OUT_READY;
            assign IN_READY = in_ready_r;
            assign COUNT    = state;

            // IN_READY is a pure register so no path exists from OUT_READY back upstream;
            // the skid entry absorbs the one beat accepted while that register catches up.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    state      <= EMPTY;
                    in_ready_r <= 1'b1;
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    skid_data  <= '0;
                    skid_ctrl  <= '0;
                end else if (FLUSH) begin
                    state      <= EMPTY;
                    in_ready_r <= 1'b1;
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_ctrl  <= '0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                main_valid <= 1'b1;
                                main_data  <= IN_DATA;
                                main_ctrl  <= IN_CTRL;
                                state      <= ONE;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_data <= IN_DATA;
                                main_ctrl <= IN_CTRL;
                            end else if (in_fire) begin
                                skid_data  <= IN_DATA;
                                skid_ctrl  <= IN_CTRL;
                                state      <= FULL;
                                in_ready_r <= 1'b0;
                            end else if (out_fire) begin
                                main_valid <= 1'b0;
                                main_ctrl  <= '0;
                                state      <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                main_data  <= skid_data;
                                main_ctrl  <= skid_ctrl;
                                skid_ctrl  <= '0;
                                state      <= ONE;
                                in_ready_r <= 1'b1;
                            end
                        end
                        default: begin
                            state      <= EMPTY;
                            in_ready_r <= 1'b1;
                            main_valid <= 1'b0;
                            main_ctrl  <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one plain-register stage and one skid-buffered stage with shared stimulus and
// checks both against per-instance FIFO scoreboards of accepted beats.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          CLK;
    logic          RST;
    logic          FLUSH;
    logic          IN_VALID;
    logic          OUT_READY;
    logic [DW-1:0] IN_DATA;
    logic [CW-1:0] IN_CTRL;

    logic          rdy0, vld0, rdy1, vld1;
    logic [DW-1:0] dat0, dat1;
    logic [CW-1:0] ctl0, ctl1;
    logic [1:0]    cnt0, cnt1;

    beat_t sb[2][$];
    int    tests = 0;
    int    fails = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy0), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
        .OUT_VALID(vld0), .OUT_READY(OUT_READY), .OUT_DATA(dat0), .OUT_CTRL(ctl0),
        .COUNT(cnt0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(rdy1), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
        .OUT_VALID(vld1), .OUT_READY(OUT_READY), .OUT_DATA(dat1), .OUT_CTRL(ctl1),
        .COUNT(cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // The model is just the ordered list of beats each stage has accepted and not yet
    // delivered; occupancy, readiness and output contents all follow from it.
    task automatic checkOutput(input int k, input logic rdy, input logic vld,
                               input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic [1:0] cnt);
        int   sz;
        logic exp_rdy;
        sz      = sb[k].size();
        exp_rdy = (k == 0) ? (sz == 0 || OUT_READY) : (sz != 2);
        check($sformatf("dut%0d.in_ready", k), 128'(rdy), 128'(exp_rdy));
        check($sformatf("dut%0d.count", k), 128'(cnt), 128'(sz));
        check($sformatf("dut%0d.out_valid", k), 128'(vld), 128'(sz != 0));
        if (vld && sz != 0) begin
            check($sformatf("dut%0d.out_data", k), 128'(d), 128'(sb[k][0].d));
            check($sformatf("dut%0d.out_ctrl", k), 128'(c), 128'(sb[k][0].c));
        end
        if (!vld)
            check($sformatf("dut%0d.bubble_ctrl", k), 128'(c), 128'(0));
        if (vld && OUT_READY && sz != 0)
            void'(sb[k].pop_front());
        if (FLUSH)
            sb[k].delete();
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            sb[0].delete();
            sb[1].delete();
        end else begin
            checkOutput(0, rdy0, vld0, dat0, ctl0, cnt0);
            checkOutput(1, rdy1, vld1, dat1, ctl1, cnt1);
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic ordy, input logic fl, input logic rs);
        @(posedge CLK);
        #1;
        IN_VALID  = v;
        IN_DATA   = d;
        IN_CTRL   = c;
        OUT_READY = ordy;
        FLUSH     = fl;
        RST       = rs;
        @(negedge CLK);
        #1;
        if (!rs && !fl && v) begin
            if (rdy0) sb[0].push_back({d, c});
            if (rdy1) sb[1].push_back({d, c});
        end
    endtask

    task automatic checkZeroAfterReset();
        check("dut0.reset_data", 128'(dat0), 128'(0));
        check("dut1.reset_data", 128'(dat1), 128'(0));
        check("dut0.reset_ctrl", 128'(ctl0), 128'(0));
        check("dut1.reset_ctrl", 128'(ctl1), 128'(0));
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_DATA = '0; IN_CTRL = '0;

        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkZeroAfterReset();

        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, DW'(i), 16'h00FF, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Stall while A, B, C are offered, then release and keep offering C.
        applyStimulus(1'b1, DW'('hA), 16'h0A0A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('hB), 16'h0B0B, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('hC), 16'h0C0C, 1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, DW'('hC), 16'h0C0C, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, DW'('h11), 16'h1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, DW'('h12), 16'hFFFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('h13), 16'h1313, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Fill, flush with D on the input, then E flows normally.
        applyStimulus(1'b1, DW'('h21), 16'h2121, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('h22), 16'h2222, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('hD), 16'h0D0D, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, DW'('hE), 16'h0E0E, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Reset while full and stalled.
        applyStimulus(1'b1, DW'('h31), 16'h3131, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('h32), 16'h3232, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DW'('h33), 16'h3333, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checkZeroAfterReset();
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 4) != 0,
                          {$urandom, $urandom, $urandom},
                          16'($urandom),
                          ($urandom % 10) < 7,
                          ($urandom % 30) == 0,
                          ($urandom % 100) == 0);
        end
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying one instruction's datapath payload and control bits between any two stages of the RV32IM pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds a valid/ready handshake, stall back-pressure, flush-to-bubble, an occupancy count and an optional two-entry skid buffer that registers the ready path. Control bits are forced to zero whenever the stage holds a bubble, so downstream logic that ignores VALID still sees a NOP.

## Interface
- DATA_W, 96: payload width (PC, operands, immediate, rd, funct3, PC+4, packed by the instantiating stage)
- CTRL_W, 16: control-bit width (write enable, mem read/write, branch, jump, ALU control, ...); zeroed on bubble
- SKID, 1: 0 = single register with combinational IN_READY; 1 = two-entry skid buffer with registered IN_READY

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  kill all stage contents (mispredict/jump redirect)
- IN_VALID  in  1  upstream beat valid
- IN_READY  out  1  stage can accept a beat
- IN_DATA  in  DATA_W  upstream payload
- IN_CTRL  in  CTRL_W  upstream control bits
- OUT_VALID  out  1  downstream beat valid
- OUT_READY  in  1  downstream accepts (deasserted = stall)
- OUT_DATA  out  DATA_W  payload to next stage
- OUT_CTRL  out  CTRL_W  control to next stage; 0 whenever OUT_VALID=0
- COUNT  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)

## Operation
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Priority per edge: RST > FLUSH > normal update.
- RST: OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, COUNT=0, skid entry invalid and zero. IN_READY=1 from the first cycle after RST deasserts.
- FLUSH: next cycle OUT_VALID=0, OUT_CTRL=0, COUNT=0, skid entry discarded. A beat presented with IN_VALID in the FLUSH cycle is dropped; upstream treats it as consumed if IN_READY was high. OUT_DATA holds its value.
- SKID=0:
  - IN_READY = ~OUT_VALID | OUT_READY (combinational).
  - When IN_READY is high, the register loads IN_VALID, IN_DATA, and either IN_CTRL (if IN_VALID) or 0.
  - When IN_READY is low, the register holds.
- SKID=1, states EMPTY (COUNT=0), ONE (1), FULL (2); IN_READY = (state != FULL), registered:
  - EMPTY: in_fire -> ONE, main loads input.
  - ONE: in_fire & out_fire -> ONE, main loads input. in_fire & ~out_fire -> FULL, skid loads input. ~in_fire & out_fire -> EMPTY, main ctrl zeroed. Neither -> hold.
  - FULL: IN_READY=0. out_fire -> ONE, main loads skid and the skid is invalidated. Otherwise hold.
- OUT_* always drive the main entry. Ordering is strictly FIFO. No beat is duplicated or lost except by FLUSH.
- In a bubble, OUT_DATA holds its last value. Benches do not check it while OUT_VALID=0.

## Timing
- Latency: 1 cycle from in_fire to OUT_VALID for the same beat (both modes, stage empty).
- Throughput: 1 beat/cycle when OUT_READY is held high, both modes.
- SKID=1: IN_READY has no combinational path from OUT_READY. It deasserts the cycle after the FULL transition and reasserts the cycle after the out_fire that leaves FULL.
- SKID=0: combinational OUT_READY -> IN_READY path, one gate level.
- A stall (OUT_READY=0) holds OUT_VALID, OUT_DATA and OUT_CTRL stable until out_fire or FLUSH.
- A simultaneous FLUSH and out_fire counts the downstream beat as delivered. The stage is still empty next cycle.

## Test plan
- Reset, then stream with OUT_READY=1: payloads 0x1..0x8, one per cycle, IN_CTRL=0x00FF. Outputs appear one cycle later in order with OUT_CTRL=0x00FF, COUNT=1, no gaps.
- Stall, SKID=1: hold OUT_READY=0 for 3 cycles while A, B, C are offered. A sits at OUT_*, B is captured in skid, IN_READY=0 the cycle after B, C is held upstream and COUNT=2. Release: A, B, C are delivered on consecutive cycles.
- Same stall, SKID=0: IN_READY drops in the same cycle OUT_READY=0 while OUT_VALID=1. Only A is held and COUNT=1.
- Bubble: IN_VALID=0 for one cycle mid-stream with IN_CTRL=0xFFFF. The matching output cycle has OUT_VALID=0 and OUT_CTRL=0x0000.
- FLUSH while FULL with IN_VALID=1 carrying D. Next cycle OUT_VALID=0, COUNT=0, IN_READY=1; D never appears. The next beat E emerges normally.
- RST asserted mid-stream while FULL, with OUT_READY=0. Next cycle all outputs are zero, COUNT=0, and no stale beat appears after RST is released.
